mmio_stepper_cmd: RTL and testbench



---
 rtl/mmio_cmd_pkg.sv | 48 ++++
 rtl/stepper_phase_gen.sv | 48 ++++
 rtl/mmio_stepper_cmd.sv | 222 ++++++++++++++++++++++
 tb/tb_mmio_stepper_cmd.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_cmd_pkg.sv
// mmio_cmd_pkg: command word layout, FSM encodings, status layout and coil phase table
// shared by the stepper command consumer and its per-axis phase generators.
package mmio_cmd_pkg;

  localparam int CMD_CNT_MSB   = 15;
  localparam int CMD_AXIS_BIT  = 16;
  localparam int CMD_DIR_BIT   = 17;
  localparam int CMD_CLAW_BIT  = 18;
  localparam int CMD_CLR_BIT   = 30;
  localparam int CMD_ABORT_BIT = 31;

  localparam int STAT_BUSY_BIT  = 31;
  localparam int STAT_PEND_BIT  = 30;
  localparam int STAT_LIMIT_BIT = 29;
  localparam int STAT_OVF_BIT   = 28;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CLAW = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Field order matches data[18:0] so a command word can be cast directly.
  typedef struct packed {
    logic        claw;
    logic        dir;
    logic        axis;
    logic [15:0] count;
  } cmd_t;

  typedef struct packed {
    logic claw;
    logic dir;
    logic axis;
  } move_t;

  function automatic logic [3:0] phase_of(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      2'd3:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// stepper_phase_gen: 2-bit coil index with step/dir control and a registered 4-bit phase output.
// Build option MMIO_STEPPER_HOLD_EN: keep the last pattern while disabled instead of driving 4'b0000.
module stepper_phase_gen
  import mmio_cmd_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       step,
  input  logic       dir,
  input  logic       enable,
  output logic [3:0] phase
);

  logic [1:0] idx_r;
  logic [1:0] idx_nx_s;

  // Next coil index: reverse steps wrap 0 -> 3, forward steps wrap 3 -> 0.
  always_comb begin
    if (step && dir) begin
      idx_nx_s = idx_r - 2'd1;
    end else if (step) begin
      idx_nx_s = idx_r + 2'd1;
    end else begin
      idx_nx_s = idx_r;
    end
  end

  // Index and phase registers; the enabled pattern already reflects a step taken this edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_r <= 2'd0;
      phase <= 4'b0000;
    end else begin
      idx_r <= idx_nx_s;
      if (enable) begin
        phase <= phase_of(idx_nx_s);
`ifdef MMIO_STEPPER_HOLD_EN
      end else begin
        phase <= phase;
`else
      end else begin
        phase <= 4'b0000;
`endif
      end
    end
  end

endmodule

// File: rtl/mmio_stepper_cmd.sv
// mmio_stepper_cmd: snoops dmem stores to CMD_ADDR and executes them as X/Y stepper moves
// with an optional claw-drop pulse. Build option MMIO_STEPPER_HOLD_EN keeps coils energized when idle.
module mmio_stepper_cmd
  import mmio_cmd_pkg::*;
#(
  parameter logic [11:0] CMD_ADDR = 12'd1001,
  parameter int unsigned STEP_DIV = 32'd100000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wren,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        stop_x,
  input  logic        stop_y,
  output logic [3:0]  x_phase,
  output logic [3:0]  y_phase,
  output logic        claw_go,
  output logic        busy,
  output logic [31:0] status
);

  localparam int DIV_W = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 32'd1);

  logic [1:0]       state_r,       state_nx;
  move_t            move_r,        move_nx;
  logic [15:0]      rem_r,         rem_nx;
  logic [DIV_W-1:0] div_r,         div_nx;
  cmd_t             pend_r,        pend_nx;
  logic             pend_valid_r,  pend_valid_nx;
  logic             limit_r,       limit_nx;
  logic             ovf_r,         ovf_nx;
  logic             busy_r;
  logic             claw_go_r;
  logic             sx_meta_r, sx_sync_r, sy_meta_r, sy_sync_r;

  cmd_t             wr_cmd_s;
  cmd_t             load_cmd_s;
  logic             wr_s, enq_s, load_s, step_s, stop_s;
  logic             x_en_s, y_en_s;
  logic [31:0]      status_s;
  logic             data_unused_s;

  assign wr_cmd_s      = cmd_t'(data[CMD_CLAW_BIT:0]);
  assign data_unused_s = ^data[29:19];

  // Two-flop synchronizers for the asynchronous limit switches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sx_meta_r <= 1'b0;
      sx_sync_r <= 1'b0;
      sy_meta_r <= 1'b0;
      sy_sync_r <= 1'b0;
    end else begin
      sx_meta_r <= stop_x;
      sx_sync_r <= sx_meta_r;
      sy_meta_r <= stop_y;
      sy_sync_r <= sy_meta_r;
    end
  end

  // Command decode, pending routing, step divider and move sequencing.
  always_comb begin
    state_nx      = state_r;
    move_nx       = move_r;
    rem_nx        = rem_r;
    div_nx        = div_r;
    pend_nx       = pend_r;
    pend_valid_nx = pend_valid_r;
    limit_nx      = limit_r;
    ovf_nx        = ovf_r;
    load_s        = 1'b0;
    load_cmd_s    = pend_r;
    step_s        = 1'b0;
    wr_s          = wren && (address_dmem == CMD_ADDR);
    enq_s         = wr_s && !data[CMD_ABORT_BIT]
                    && ((wr_cmd_s.count != 16'd0) || wr_cmd_s.claw);
    stop_s        = move_r.axis ? sy_sync_r : sx_sync_r;

    if (wr_s && data[CMD_CLR_BIT]) begin
      limit_nx = 1'b0;
      ovf_nx   = 1'b0;
    end else begin
      limit_nx = limit_r;
      ovf_nx   = ovf_r;
    end

    // Enqueue is resolved first so a write landing in DONE is visible to the pending load.
    if (enq_s && (state_r == ST_IDLE) && !pend_valid_r) begin
      load_s     = 1'b1;
      load_cmd_s = wr_cmd_s;
    end else if (enq_s && !pend_valid_r) begin
      pend_nx       = wr_cmd_s;
      pend_valid_nx = 1'b1;
    end else if (enq_s) begin
      ovf_nx = 1'b1;
    end else begin
      pend_nx = pend_r;
    end

    if (wr_s && data[CMD_ABORT_BIT]) begin
      state_nx      = ST_IDLE;
      rem_nx        = 16'd0;
      div_nx        = '0;
      pend_valid_nx = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_RUN: begin
          if (stop_s) begin
            rem_nx   = 16'd0;
            div_nx   = '0;
            limit_nx = 1'b1;
            state_nx = ST_DONE;
          end else if (rem_r == 16'd0) begin
            div_nx   = '0;
            state_nx = move_r.claw ? ST_CLAW : ST_DONE;
          end else if (div_r == DIV_LAST) begin
            div_nx = '0;
            step_s = 1'b1;
            rem_nx = rem_r - 16'd1;
          end else begin
            div_nx = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
        ST_CLAW: begin
          state_nx = ST_DONE;
        end
        ST_DONE: begin
          if (pend_valid_nx) begin
            load_s        = 1'b1;
            load_cmd_s    = pend_nx;
            pend_valid_nx = 1'b0;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase

      if (load_s) begin
        move_nx.claw = load_cmd_s.claw;
        move_nx.dir  = load_cmd_s.dir;
        move_nx.axis = load_cmd_s.axis;
        rem_nx       = load_cmd_s.count;
        div_nx       = '0;
        state_nx     = (load_cmd_s.count != 16'd0) ? ST_RUN : ST_CLAW;
      end else begin
        move_nx = move_nx;
      end
    end
  end

  // Sequencer state, sticky flags and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      move_r       <= '0;
      rem_r        <= 16'd0;
      div_r        <= '0;
      pend_r       <= '0;
      pend_valid_r <= 1'b0;
      limit_r      <= 1'b0;
      ovf_r        <= 1'b0;
      busy_r       <= 1'b0;
      claw_go_r    <= 1'b0;
    end else begin
      state_r      <= state_nx;
      move_r       <= move_nx;
      rem_r        <= rem_nx;
      div_r        <= div_nx;
      pend_r       <= pend_nx;
      pend_valid_r <= pend_valid_nx;
      limit_r      <= limit_nx;
      ovf_r        <= ovf_nx;
      busy_r       <= (state_nx != ST_IDLE);
      claw_go_r    <= (state_nx == ST_CLAW);
    end
  end

  // Drive enables look at next state so the first pattern appears on RUN entry.
  assign x_en_s = (state_nx == ST_RUN) && !move_nx.axis;
  assign y_en_s = (state_nx == ST_RUN) &&  move_nx.axis;

  stepper_phase_gen u_x_phase (
    .clock   (clock),
    .reset_n (reset_n),
    .step    (step_s && !move_r.axis),
    .dir     (move_r.dir),
    .enable  (x_en_s),
    .phase   (x_phase)
  );

  stepper_phase_gen u_y_phase (
    .clock   (clock),
    .reset_n (reset_n),
    .step    (step_s && move_r.axis),
    .dir     (move_r.dir),
    .enable  (y_en_s),
    .phase   (y_phase)
  );

  // Status word assembled from registered flags for the read-back mux.
  always_comb begin
    status_s                 = 32'd0;
    status_s[STAT_BUSY_BIT]  = busy_r;
    status_s[STAT_PEND_BIT]  = pend_valid_r;
    status_s[STAT_LIMIT_BIT] = limit_r;
    status_s[STAT_OVF_BIT]   = ovf_r;
    status_s[CMD_CNT_MSB:0]  = rem_r;
  end

  assign status  = status_s;
  assign busy    = busy_r;
  assign claw_go = claw_go_r;

endmodule

// File: tb/tb_mmio_stepper_cmd.sv
// tb_mmio_stepper_cmd: scenario tasks plus randomized moves checked against a timeline model
// of the command block (STEP_DIV=4, default build without coil hold).
module tb_mmio_stepper_cmd;

  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wren = 1'b0;
  logic [11:0] address_dmem = 12'd0;
  logic [31:0] data = 32'd0;
  logic        stop_x = 1'b0;
  logic        stop_y = 1'b0;
  logic [3:0]  x_phase, y_phase;
  logic        claw_go, busy;
  logic [31:0] status;

  int n_checks = 0;
  int n_fail   = 0;
  int idx_x    = 0;
  int idx_y    = 0;

  mmio_stepper_cmd #(.CMD_ADDR(12'd1001), .STEP_DIV(DIV)) dut (
    .clock(clock), .reset_n(reset_n), .wren(wren), .address_dmem(address_dmem),
    .data(data), .stop_x(stop_x), .stop_y(stop_y), .x_phase(x_phase),
    .y_phase(y_phase), .claw_go(claw_go), .busy(busy), .status(status)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] pat(input int i);
    int m;
    m = ((i % 4) + 4) % 4;
    case (m)
      0: return 4'b1100;
      1: return 4'b0110;
      2: return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_cmd(input logic [31:0] w);
    wren = 1'b1; address_dmem = 12'd1001; data = w;
    tick();
    wren = 1'b0; address_dmem = 12'd0; data = 32'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({x_phase, y_phase, claw_go, busy} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 000", {x_phase, y_phase, claw_go, busy});
    end
    n_checks++;
    if (status !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want 0", status); end
    reset_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_x_fwd();
    logic [3:0] exp_x [0:3];
    exp_x[0] = 4'b1100; exp_x[1] = 4'b0110; exp_x[2] = 4'b0011; exp_x[3] = 4'b1001;
    write_cmd(32'h0000_0003);
    for (int t = 0; t <= 15; t++) begin
      if ((t % 4 == 0) && (t <= 12)) begin
        n_checks++;
        if (x_phase !== exp_x[t/4]) begin
          n_fail++; $display("FAIL x_fwd_phase t=%0d got %b want %b", t, x_phase, exp_x[t/4]);
        end
      end
      n_checks++;
      if (claw_go !== 1'b0) begin n_fail++; $display("FAIL x_fwd_claw t=%0d got %b want 0", t, claw_go); end
      if (t == 13 || t == 14) begin
        n_checks++;
        if (busy !== (t == 13)) begin n_fail++; $display("FAIL x_fwd_busy t=%0d got %b want %b", t, busy, t == 13); end
      end
      tick();
    end
    idx_x = 3;
  endtask

  task automatic test_y_claw();
    write_cmd(32'h0007_0002);
    for (int t = 0; t <= 11; t++) begin
      if (t == 0 && y_phase !== 4'b1100) begin n_fail++; $display("FAIL y_claw_phase0 got %b want 1100", y_phase); end
      if (t == 4 && y_phase !== 4'b1001) begin n_fail++; $display("FAIL y_claw_phase1 got %b want 1001", y_phase); end
      if (t == 8 && y_phase !== 4'b0011) begin n_fail++; $display("FAIL y_claw_phase2 got %b want 0011", y_phase); end
      if (t == 0 || t == 4 || t == 8) n_checks++;
      n_checks++;
      if (claw_go !== (t == 9)) begin n_fail++; $display("FAIL y_claw_pulse t=%0d got %b want %b", t, claw_go, t == 9); end
      n_checks++;
      if (x_phase !== 4'b0000) begin n_fail++; $display("FAIL y_claw_xidle t=%0d got %b want 0000", t, x_phase); end
      if (t >= 10) begin
        n_checks++;
        if (busy !== (t == 10)) begin n_fail++; $display("FAIL y_claw_busy t=%0d got %b want %b", t, busy, t == 10); end
      end
      tick();
    end
    idx_y = 2;
  endtask

  task automatic test_back_to_back();
    int budget;
    write_cmd(32'h0000_0005);
    write_cmd(32'h0001_0005);
    write_cmd(32'h0000_0005);
    n_checks++;
    if (status[30] !== 1'b1 || status[28] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_pend_ovf got pend=%b ovf=%b want 1 1", status[30], status[28]);
    end
    for (int t = 2; t <= 26; t++) begin
      if (t == 20) begin
        n_checks++;
        if (x_phase !== pat(idx_x + 5)) begin n_fail++; $display("FAIL b2b_first_last got %b want %b", x_phase, pat(idx_x + 5)); end
      end
      if (t == 21) begin
        n_checks++;
        if (busy !== 1'b1 || status[30] !== 1'b1 || x_phase !== 4'b0000) begin
          n_fail++; $display("FAIL b2b_done got busy=%b pend=%b x=%b want 1 1 0000", busy, status[30], x_phase);
        end
      end
      if (t == 22) begin
        n_checks++;
        if (status[30] !== 1'b0 || y_phase !== pat(idx_y) || status[15:0] !== 16'd5) begin
          n_fail++; $display("FAIL b2b_second_start got pend=%b y=%b rem=%0d want 0 %b 5", status[30], y_phase, status[15:0], pat(idx_y));
        end
      end
      if (t == 26) begin
        n_checks++;
        if (y_phase !== pat(idx_y + 1)) begin n_fail++; $display("FAIL b2b_second_step got %b want %b", y_phase, pat(idx_y + 1)); end
      end
      tick();
    end
    budget = 0;
    while (busy === 1'b1 && budget < 100) begin tick(); budget++; end
    n_checks++;
    if (budget >= 100) begin n_fail++; $display("FAIL b2b_idle_timeout got busy=%b want 0", busy); end
    idx_x = (idx_x + 5) % 4;
    idx_y = (idx_y + 5) % 4;
    n_checks++;
    if (status[28] !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf_sticky got %b want 1", status[28]); end
    write_cmd(32'h4000_0000);
    n_checks++;
    if (status[28] !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ovf_clear got ovf=%b busy=%b want 0 0", status[28], busy);
    end
  endtask

  task automatic test_limit();
    logic [3:0] held;
    write_cmd(32'h0004_0064);
    for (int t = 0; t < 40; t++) tick();
    held = pat(idx_x + 10);
    n_checks++;
    if (x_phase !== held) begin n_fail++; $display("FAIL limit_step10 got %b want %b", x_phase, held); end
    stop_x = 1'b1;
    for (int t = 41; t <= 46; t++) begin
      tick();
      if (t <= 42) begin
        n_checks++;
        if (x_phase !== held) begin n_fail++; $display("FAIL limit_hold t=%0d got %b want %b", t, x_phase, held); end
      end
      if (t == 43) begin
        n_checks++;
        if (x_phase !== 4'b0000 || busy !== 1'b1 || status[29] !== 1'b1 || status[15:0] !== 16'd0) begin
          n_fail++; $display("FAIL limit_done got x=%b busy=%b lim=%b rem=%0d want 0000 1 1 0", x_phase, busy, status[29], status[15:0]);
        end
      end
      if (t == 44) begin
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL limit_idle got %b want 0", busy); end
      end
      n_checks++;
      if (claw_go !== 1'b0) begin n_fail++; $display("FAIL limit_claw t=%0d got %b want 0", t, claw_go); end
    end
    stop_x = 1'b0;
    idx_x = (idx_x + 10) % 4;
    tick(); tick(); tick();
    write_cmd(32'h4000_0000);
    n_checks++;
    if (status[29] !== 1'b0) begin n_fail++; $display("FAIL limit_clear got %b want 0", status[29]); end
  endtask

  task automatic test_abort();
    int seen_busy;
    write_cmd(32'h0000_0014);
    write_cmd(32'h0001_0003);
    n_checks++;
    if (status[30] !== 1'b1) begin n_fail++; $display("FAIL abort_pend_set got %b want 1", status[30]); end
    for (int t = 1; t < 7; t++) tick();
    n_checks++;
    if (x_phase !== pat(idx_x + 1)) begin n_fail++; $display("FAIL abort_prestep got %b want %b", x_phase, pat(idx_x + 1)); end
    write_cmd(32'h8000_0000);
    n_checks++;
    if (busy !== 1'b0 || status[30] !== 1'b0 || status[15:0] !== 16'd0 || x_phase !== 4'b0000) begin
      n_fail++; $display("FAIL abort_idle got busy=%b pend=%b rem=%0d x=%b want 0 0 0 0000", busy, status[30], status[15:0], x_phase);
    end
    seen_busy = 0;
    for (int t = 0; t < 20; t++) begin
      if (busy !== 1'b0) seen_busy++;
      tick();
    end
    n_checks++;
    if (seen_busy != 0) begin n_fail++; $display("FAIL abort_pend_dropped got %0d busy cycles want 0", seen_busy); end
    idx_x = (idx_x + 1) % 4;
  endtask

  task automatic test_random();
    int n, ax, rv, cl, base, exp_rem;
    logic [3:0] exp_act;
    logic exp_busy, exp_claw;
    logic [31:0] w;
    wren = 1'b1; address_dmem = 12'd1002; data = 32'h0000_0003;
    tick();
    wren = 1'b0; address_dmem = 12'd1001;
    tick();
    data = 32'd0; address_dmem = 12'd0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_decode got busy=%b want 0", busy); end
    for (int it = 0; it < 8; it++) begin
      n  = $urandom_range(1, 6);
      ax = $urandom_range(0, 1);
      rv = $urandom_range(0, 1);
      cl = $urandom_range(0, 1);
      w = 32'd0;
      w[15:0] = n[15:0];
      w[16] = ax[0]; w[17] = rv[0]; w[18] = cl[0];
      base = (ax != 0) ? idx_y : idx_x;
      write_cmd(w);
      for (int t = 0; t <= 4*n + 3; t++) begin
        exp_act  = (t <= 4*n) ? pat((rv != 0) ? base - t/4 : base + t/4) : 4'b0000;
        exp_busy = (t <= 4*n + ((cl != 0) ? 2 : 1));
        exp_claw = (cl != 0) && (t == 4*n + 1);
        exp_rem  = (t <= 4*n) ? n - t/4 : 0;
        n_checks++;
        if (((ax != 0) ? y_phase : x_phase) !== exp_act) begin
          n_fail++; $display("FAIL rand_active it=%0d t=%0d got %b want %b", it, t, (ax != 0) ? y_phase : x_phase, exp_act);
        end
        n_checks++;
        if (((ax != 0) ? x_phase : y_phase) !== 4'b0000) begin
          n_fail++; $display("FAIL rand_inactive it=%0d t=%0d got %b want 0000", it, t, (ax != 0) ? x_phase : y_phase);
        end
        n_checks++;
        if (claw_go !== exp_claw) begin n_fail++; $display("FAIL rand_claw it=%0d t=%0d got %b want %b", it, t, claw_go, exp_claw); end
        n_checks++;
        if (busy !== exp_busy || status[31] !== exp_busy) begin
          n_fail++; $display("FAIL rand_busy it=%0d t=%0d got %b/%b want %b", it, t, busy, status[31], exp_busy);
        end
        n_checks++;
        if (status[15:0] !== exp_rem[15:0] || status[30] !== 1'b0) begin
          n_fail++; $display("FAIL rand_status it=%0d t=%0d got rem=%0d pend=%b want %0d 0", it, t, status[15:0], status[30], exp_rem);
        end
        tick();
      end
      if (ax != 0) idx_y = (((rv != 0) ? base - n : base + n) % 4 + 4) % 4;
      else         idx_x = (((rv != 0) ? base - n : base + n) % 4 + 4) % 4;
    end
  endtask

  task automatic test_reset_mid();
    write_cmd(32'h0000_000A);
    for (int t = 0; t < 5; t++) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_running got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({x_phase, y_phase, claw_go, busy} !== 10'd0 || status !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_async got out=%h status=%h want 000 0", {x_phase, y_phase, claw_go, busy}, status);
    end
    tick();
    reset_n = 1'b1;
    tick();
    idx_x = 0;
    idx_y = 0;
  endtask

  initial begin
    test_reset();
    test_x_fwd();
    test_y_claw();
    test_back_to_back();
    test_limit();
    test_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
